// File: rtl/pipe_stage_hs.sv
// Falling-edge pipeline register stage with a valid/ready handshake, flush, an optional
// two-entry skid buffer, NOP presentation when empty and a saturating bubble counter.
module pipe_stage_hs #(
    parameter int                INST_W   = 32,
    parameter int                DATA_W   = 96,
    parameter logic [INST_W-1:0] NOP_INST = 32'h00000033,
    parameter bit                SKID     = 1'b1,
    parameter int                CNT_W    = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [INST_W-1:0] in_inst,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [INST_W-1:0] out_inst,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy,
    input  logic              cnt_clr,
    output logic [CNT_W-1:0]  bubble_cnt
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        FULL  = 2'd1,
        SKIDF = 2'd2
    } state_e;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_e              state_q, state_d;
    logic [INST_W-1:0]   m_inst_q, m_inst_d, s_inst_q, s_inst_d;
    logic [DATA_W-1:0]   m_data_q, m_data_d, s_data_q, s_data_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                in_fire, out_fire, has_entry;

    assign has_entry = (state_q != EMPTY);
    assign out_valid = has_entry && !stall;
    assign out_inst  = has_entry ? m_inst_q : NOP_INST;
    assign out_data  = has_entry ? m_data_q : '0;
    assign occupancy = state_q;
    assign bubble_cnt = cnt_q;

    // The skid form keeps in_ready off the downstream out_ready path.
    generate
        if (SKID) begin : g_skid
            assign in_ready = !stall && !flush && (state_q != SKIDF);
        end else begin : g_single
            assign in_ready = !stall && !flush && (!out_valid || out_ready);
        end
    endgenerate

    assign in_fire  = in_valid && in_ready;
    assign out_fire = out_valid && out_ready;

    always_comb begin
        state_d  = state_q;
        m_inst_d = m_inst_q;
        m_data_d = m_data_q;
        s_inst_d = s_inst_q;
        s_data_d = s_data_q;
        if (flush) begin
            state_d = EMPTY;
        end else if (!stall) begin
            unique case (state_q)
                EMPTY: begin
                    if (in_fire) begin
                        state_d  = FULL;
                        m_inst_d = in_inst;
                        m_data_d = in_data;
                    end
                end
                FULL: begin
                    if (in_fire && out_fire) begin
                        m_inst_d = in_inst;
                        m_data_d = in_data;
                    end else if (in_fire) begin
                        if (SKID) begin
                            state_d  = SKIDF;
                            s_inst_d = in_inst;
                            s_data_d = in_data;
                        end
                    end else if (out_fire) begin
                        state_d = EMPTY;
                    end
                end
                SKIDF: begin
                    if (out_fire) begin
                        state_d  = FULL;
                        m_inst_d = s_inst_q;
                        m_data_d = s_data_q;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    // Bubble counter: clear beats increment, saturates rather than wrapping, ignores flush.
    always_comb begin
        cnt_d = cnt_q;
        if (cnt_clr) begin
            cnt_d = '0;
        end else if (out_ready && !out_valid && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(negedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= EMPTY;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Payload registers carry no reset; outputs are masked by state while empty.
    always_ff @(negedge clk) begin
        m_inst_q <= m_inst_d;
        m_data_q <= m_data_d;
        s_inst_q <= s_inst_d;
        s_data_q <= s_data_d;
    end

endmodule
